key_move_ctrl: RTL and testbench
================================

KEY_MOVE_CTRL -- requirements
Module: key_move_ctrl

Interface
REQ-001 Parameter: REPEAT_DELAY, 32_500_000, clock cycles from the first move pulse of a held key to the first auto-repeat pulse (min 2).
REQ-002 Parameter: REPEAT_PERIOD, 6_500_000, clock cycles between subsequent auto-repeat pulses (min 2).
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: keycode  input  16  PS/2 set-2 byte history; [7:0] is the newest byte, [15:8] is ignored.
REQ-006 Port: keycode_valid  input  1  one-cycle strobe; keycode[7:0] holds a newly received byte.
REQ-007 Port: move_up / move_down / move_left / move_right  output  1 each  registered one-cycle move pulses to top_vga.

Function
REQ-008 The block SHALL sample keycode[7:0] only in cycles where keycode_valid=1.
REQ-009 The decoder FSM SHALL have the states IDLE, EXT, BRK and EXT_BRK.
REQ-010 IDLE transitions: E0->EXT; F0->BRK; 1D/1B/1C/23 (W/S/A/D) = make up/down/left/right, stay IDLE; any other byte stays IDLE.
REQ-011 EXT transitions: F0->EXT_BRK; 75/72/6B/74 = make up/down/left/right ->IDLE; any other byte ->IDLE with no event.
REQ-012 BRK: any byte ->IDLE; if the byte is 1D/1B/1C/23 it SHALL be a break of that direction.
REQ-013 EXT_BRK: any byte ->IDLE; if the byte is 75/72/6B/74 it SHALL be a break of that direction.
REQ-014 A register active_dir (NONE/UP/DOWN/LEFT/RIGHT) SHALL hold the single currently held direction.
REQ-015 Make of a direction different from active_dir: active_dir <= that direction; pulse that output in the cycle after the strobe (latency 1); counter cleared; phase=DELAY.
REQ-016 Make equal to active_dir (keyboard typematic repeat): no pulse; counter and phase unchanged.
REQ-017 Break equal to active_dir: active_dir <= NONE; counter cleared; no pulse.
REQ-018 Break not equal to active_dir: ignored.
REQ-019 While active_dir != NONE and no event occurs, the counter SHALL increment every cycle.
REQ-020 In phase DELAY, when counter = REPEAT_DELAY-1: pulse active_dir, counter <= 0, phase <= PERIOD.
REQ-021 In phase PERIOD, when counter = REPEAT_PERIOD-1: pulse active_dir, counter <= 0.
REQ-022 The counter width SHALL be $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)); it SHALL never wrap.
REQ-023 At most one move output SHALL be high in any cycle, and every pulse SHALL last exactly one cycle.
REQ-024 If a decoded make/break that changes active_dir coincides with a repeat expiry, the event SHALL take precedence and the repeat pulse SHALL be suppressed.
REQ-025 A filtered typematic make (REQ-016) coinciding with an expiry SHALL NOT block the repeat pulse.
REQ-026 While active_dir = NONE, the counter SHALL hold 0 and no pulses SHALL be produced.

Reset
REQ-027 While rst=1: FSM=IDLE, active_dir=NONE, counter=0, phase=DELAY, all move outputs 0, asynchronously.
REQ-028 Assertion of rst mid-sequence (e.g. after E0 received) SHALL discard the partial sequence.
REQ-029 After rst deasserts, the first valid byte SHALL be decoded from IDLE.

Verification (REPEAT_DELAY=20, REPEAT_PERIOD=5 in bench)
REQ-030 Bytes E0,75 -> exactly one move_up pulse, 1 cycle after the 75 strobe; outputs otherwise 0.
REQ-031 1D held with no break -> pulses at +1, then +21 and every 5 cycles after; repeated 1D strobes add no pulses and do not restart timing.
REQ-032 E0,6B then 23 (no break of 6B) -> move_left then move_right; repeats switch to move_right only; subsequent E0,F0,6B is ignored; F0,23 stops all pulses.
REQ-033 Bytes E0,F0,74 with active_dir=NONE -> no pulse; bytes 12 (shift), E0,12 -> no pulse, FSM returns to IDLE.
REQ-034 Break strobe landing in the exact cycle of a repeat expiry -> no pulse in that cycle or afterwards.
REQ-035 rst asserted after E0 and during repeat -> outputs 0 immediately; post-reset byte 75 alone -> no pulse; 1B -> move_down.

Source files
------------

// File: rtl/key_move_ctrl.sv
// PS/2 set-2 arrow/WASD decoder producing one-cycle move pulses
// with a held-key auto-repeat (initial delay, then a fixed period).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   keycode       [7:0] newest received byte, [15:8] unused
//   keycode_valid one-cycle strobe, keycode[7:0] is new
//   move_up/down/left/right  registered one-cycle move pulses
module key_move_ctrl #(
  parameter int REPEAT_DELAY  = 32_500_000,
  parameter int REPEAT_PERIOD = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  input  logic        keycode_valid,
  output logic        move_up,
  output logic        move_down,
  output logic        move_left,
  output logic        move_right
);

  localparam int MAXC =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  typedef enum logic [2:0] {
    D_NONE,
    D_UP,
    D_DOWN,
    D_LEFT,
    D_RIGHT
  } dir_e;

  typedef enum logic {
    PH_DELAY,
    PH_PERIOD
  } phase_e;

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  phase_e          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      mv_q, mv_d;

  logic [7:0]      b;
  logic            mk, bk;
  dir_e            kdir;
  dir_e            pulse_dir;

  assign b = keycode[7:0];

  function automatic dir_e wasd(input logic [7:0] c);
    unique case (c)
      8'h1D:   wasd = D_UP;
      8'h1B:   wasd = D_DOWN;
      8'h1C:   wasd = D_LEFT;
      8'h23:   wasd = D_RIGHT;
      default: wasd = D_NONE;
    endcase
  endfunction

  function automatic dir_e arrow(input logic [7:0] c);
    unique case (c)
      8'h75:   arrow = D_UP;
      8'h72:   arrow = D_DOWN;
      8'h6B:   arrow = D_LEFT;
      8'h74:   arrow = D_RIGHT;
      default: arrow = D_NONE;
    endcase
  endfunction

  // Byte-sequence decoder: yields a make or break of one direction.
  always_comb begin
    state_d = state_q;
    mk      = 1'b0;
    bk      = 1'b0;
    kdir    = D_NONE;
    if (keycode_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (b == 8'hE0) begin
            state_d = S_EXT;
          end else if (b == 8'hF0) begin
            state_d = S_BRK;
          end else begin
            kdir = wasd(b);
            mk   = (kdir != D_NONE);
          end
        end
        S_EXT: begin
          if (b == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
            kdir    = arrow(b);
            mk      = (kdir != D_NONE);
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          kdir    = wasd(b);
          bk      = (kdir != D_NONE);
        end
        default: begin
          state_d = S_IDLE;
          kdir    = arrow(b);
          bk      = (kdir != D_NONE);
        end
      endcase
    end
  end

  // Held-direction tracker and repeat timer. An event that changes
  // the held direction wins over a coincident expiry; typematic
  // makes and foreign breaks fall through to the timer.
  always_comb begin
    dir_d     = dir_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    pulse_dir = D_NONE;
    if (mk && kdir != dir_q) begin
      dir_d     = kdir;
      cnt_d     = '0;
      phase_d   = PH_DELAY;
      pulse_dir = kdir;
    end else if (bk && kdir == dir_q) begin
      dir_d   = D_NONE;
      cnt_d   = '0;
      phase_d = PH_DELAY;
    end else if (dir_q == D_NONE) begin
      cnt_d = '0;
    end else if (phase_q == PH_DELAY && cnt_q == DLY_LAST) begin
      cnt_d     = '0;
      phase_d   = PH_PERIOD;
      pulse_dir = dir_q;
    end else if (phase_q == PH_PERIOD && cnt_q == PER_LAST) begin
      cnt_d     = '0;
      pulse_dir = dir_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    mv_d    = 4'b0000;
    mv_d[3] = (pulse_dir == D_UP);
    mv_d[2] = (pulse_dir == D_DOWN);
    mv_d[1] = (pulse_dir == D_LEFT);
    mv_d[0] = (pulse_dir == D_RIGHT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= D_NONE;
      phase_q <= PH_DELAY;
      cnt_q   <= '0;
      mv_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
    end
  end

  assign move_up    = mv_q[3];
  assign move_down  = mv_q[2];
  assign move_left  = mv_q[1];
  assign move_right = mv_q[0];

endmodule

// File: tb/tb_key_move_ctrl.sv
// Directed bench for key_move_ctrl with a short repeat delay/period.
// Move outputs are checked as {up,down,left,right} on falling edges.
module tb_key_move_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        move_up, move_down, move_left, move_right;
  logic [3:0]  mv;
  logic [3:0]  exp;

  int checks;
  int errors;

  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] DN = 4'b0100;
  localparam logic [3:0] LF = 4'b0010;
  localparam logic [3:0] RT = 4'b0001;
  localparam logic [3:0] NO = 4'b0000;

  key_move_ctrl #(
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keycode(keycode),
    .keycode_valid(keycode_valid),
    .move_up(move_up),
    .move_down(move_down),
    .move_left(move_left),
    .move_right(move_right)
  );

  assign mv = {move_up, move_down, move_left, move_right};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a falling edge; returns on the next falling edge, so the
  // strobe has been sampled and any latency-1 pulse is now visible.
  task automatic send(input logic [7:0] c);
    keycode       = {8'hA5, c};
    keycode_valid = 1'b1;
    @(negedge clk);
    keycode_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    keycode       = 16'h0000;
    keycode_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mv !== NO) begin
        errors++;
        $display("FAIL reset_hold: got %b want %b", mv, NO);
      end
    end
    send(8'h1D);
    checks++;
    if (mv !== NO) begin
      errors++;
      $display("FAIL reset_ignores_strobe: got %b want %b", mv, NO);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mv !== NO) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", mv, NO);
    end
  endtask

  task automatic test_ext_make();
    send(8'hE0);
    checks++;
    if (mv !== NO) begin
      errors++;
      $display("FAIL ext_prefix: got %b want %b", mv, NO);
    end
    send(8'h75);
    checks++;
    if (mv !== UP) begin
      errors++;
      $display("FAIL ext_up_pulse: got %b want %b", mv, UP);
    end
    for (int n = 2; n <= 15; n++) begin
      @(negedge clk);
      checks++;
      if (mv !== NO) begin
        errors++;
        $display("FAIL ext_up_quiet n=%0d: got %b want %b", n, mv, NO);
      end
    end
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      checks++;
      if (mv !== NO) begin
        errors++;
        $display("FAIL ext_up_released n=%0d: got %b want %b", n, mv, NO);
      end
    end
  endtask

  task automatic test_repeat();
    send(8'h1D);
    checks++;
    if (mv !== UP) begin
      errors++;
      $display("FAIL repeat_first: got %b want %b", mv, UP);
    end
    for (int n = 2; n <= 60; n++) begin
      @(negedge clk);
      keycode_valid = 1'b0;
      exp = NO;
      if (n == 21 || (n > 21 && n <= 41 && (n - 21) % 5 == 0))
        exp = UP;
      checks++;
      if (mv !== exp) begin
        errors++;
        $display("FAIL repeat n=%0d: got %b want %b", n, mv, exp);
      end
      case (n)
        5, 20, 25, 33: begin
          keycode = 16'h001D; keycode_valid = 1'b1;
        end
        42: begin
          keycode = 16'h00F0; keycode_valid = 1'b1;
        end
        43: begin
          keycode = 16'h001D; keycode_valid = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_switch();
    send(8'hE0);
    send(8'h6B);
    checks++;
    if (mv !== LF) begin
      errors++;
      $display("FAIL switch_left: got %b want %b", mv, LF);
    end
    for (int n = 2; n <= 50; n++) begin
      @(negedge clk);
      keycode_valid = 1'b0;
      exp = NO;
      if (n == 4 || n == 24 || n == 29 || n == 34)
        exp = RT;
      checks++;
      if (mv !== exp) begin
        errors++;
        $display("FAIL switch n=%0d: got %b want %b", n, mv, exp);
      end
      case (n)
        3: begin
          keycode = 16'h0023; keycode_valid = 1'b1;
        end
        10: begin
          keycode = 16'h00E0; keycode_valid = 1'b1;
        end
        11, 36: begin
          keycode = 16'h00F0; keycode_valid = 1'b1;
        end
        12: begin
          keycode = 16'h006B; keycode_valid = 1'b1;
        end
        37: begin
          keycode = 16'h0023; keycode_valid = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_no_event();
    logic [7:0] seq [6];
    seq = '{8'hE0, 8'hF0, 8'h74, 8'h12, 8'hE0, 8'h12};
    for (int i = 0; i < 6; i++) begin
      send(seq[i]);
      checks++;
      if (mv !== NO) begin
        errors++;
        $display("FAIL no_event i=%0d: got %b want %b", i, mv, NO);
      end
    end
    send(8'h1B);
    checks++;
    if (mv !== DN) begin
      errors++;
      $display("FAIL no_event_idle_down: got %b want %b", mv, DN);
    end
    send(8'hF0);
    send(8'h1B);
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      checks++;
      if (mv !== NO) begin
        errors++;
        $display("FAIL no_event_released n=%0d: got %b want %b", n, mv, NO);
      end
    end
  endtask

  task automatic test_break_at_expiry();
    send(8'h1C);
    checks++;
    if (mv !== LF) begin
      errors++;
      $display("FAIL brk_exp_first: got %b want %b", mv, LF);
    end
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      keycode_valid = 1'b0;
      checks++;
      if (mv !== NO) begin
        errors++;
        $display("FAIL brk_exp n=%0d: got %b want %b", n, mv, NO);
      end
      if (n == 19) begin
        keycode = 16'h00F0; keycode_valid = 1'b1;
      end else if (n == 20) begin
        keycode = 16'h001C; keycode_valid = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid();
    send(8'h1D);
    checks++;
    if (mv !== UP) begin
      errors++;
      $display("FAIL rst_mid_first: got %b want %b", mv, UP);
    end
    for (int n = 2; n <= 21; n++) begin
      @(negedge clk);
      keycode_valid = 1'b0;
      exp = (n == 21) ? UP : NO;
      checks++;
      if (mv !== exp) begin
        errors++;
        $display("FAIL rst_mid n=%0d: got %b want %b", n, mv, exp);
      end
      if (n == 20) begin
        keycode = 16'h00E0; keycode_valid = 1'b1;
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mv !== NO) begin
      errors++;
      $display("FAIL rst_mid_async: got %b want %b", mv, NO);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h75);
    checks++;
    if (mv !== NO) begin
      errors++;
      $display("FAIL rst_mid_lone_75: got %b want %b", mv, NO);
    end
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      checks++;
      if (mv !== NO) begin
        errors++;
        $display("FAIL rst_mid_idle n=%0d: got %b want %b", n, mv, NO);
      end
    end
    send(8'h1B);
    checks++;
    if (mv !== DN) begin
      errors++;
      $display("FAIL rst_mid_down: got %b want %b", mv, DN);
    end
    send(8'hF0);
    send(8'h1B);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ext_make();
    test_repeat();
    test_switch();
    test_no_event();
    test_break_at_expiry();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
